rk_demux_reg: RTL and testbench
===============================

// Module: rk_demux_reg
// PURPOSE
//  Registered, parametrised 1-to-NCH demultiplexer with valid/ready input handshake. It routes
//  round-key words (or any data words) from a single source into NCH holding registers.
//  Select is explicit (in_sel) or auto-incrementing (internal write pointer).
//  Per-channel valid flags and a fill-state FSM report load progress to the cipher datapath.
// PARAMETERS
//  WIDTH  128  data word width in bits
//  NCH    11   number of output channels (AES-128 round keys); must be >= 2
//  SELW   $clog2(NCH)  select/pointer width (localparam, derived; not overridable)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  clear      in   1           synchronous flush of all channels and the pointer
//  auto_mode  in   1           1: route to wr_ptr; 0: route to in_sel
//  in_valid   in   1           input word valid
//  in_ready   out  1           block can accept a word this cycle
//  in_sel     in   SELW        explicit channel select (used only when auto_mode=0)
//  in_data    in   WIDTH       input word
//  out_data   out  NCH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//  out_valid  out  NCH         per-channel loaded flag
//  out_wr     out  NCH         one-hot strobe: channel written on the previous edge
//  wr_ptr     out  SELW        next auto-mode target channel
//  all_loaded out  1           every channel valid (FSM in FULL)
//  sel_err    out  1           1-cycle pulse: explicit select >= NCH was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): out_data=0, out_valid=0, out_wr=0, wr_ptr=0,
//    sel_err=0, FSM=EMPTY.
//  - in_ready = ~clear & ~(auto_mode & all_loaded). It is combinational and does not depend on in_valid.
//  - Accept = in_valid & in_ready. On accept, target T = auto_mode ? wr_ptr : in_sel.
//  - Latency 1: on the edge after accept, out_data[T]<=in_data, out_valid[T]<=1,
//    out_wr=onehot(T). out_wr is 0 in every cycle without a write.
//  - Explicit mode, in_sel>=NCH: no write, no valid change; sel_err=1 for one cycle.
//    The word counts as consumed (in_ready stays 1).
//  - Explicit mode to a valid channel: overwrite it. wr_ptr does not change.
//  - Auto mode: wr_ptr increments on each accept and wraps NCH-1 -> 0.
//  - Auto mode with all channels full: in_ready=0 and further words stall until clear.
//  - Switching auto_mode mid-load is legal. wr_ptr and the channel contents are kept.
//  - clear (synchronous): out_valid=0, out_data=0, wr_ptr=0, FSM=EMPTY.
//    clear wins over a simultaneous in_valid; that word is not accepted because in_ready=0.
//  - Fill-state FSM, based on the popcount of out_valid after the update:
//      EMPTY   (no channel valid)    -> PARTIAL on the first write
//      PARTIAL (1..NCH-1 valid)      -> FULL when the last invalid channel is written
//      FULL    (all valid)           -> EMPTY only on clear or rst
//    all_loaded = (state==FULL), registered.
//  - Reset asserted mid-load: everything returns to reset values immediately.
//    No partial word is ever retained.
//  - All outputs are registered except in_ready.
// STRUCTURE
//  - Shared package aes_cu_pkg provides:
//      AES_NUM_RK=11, AES_WORD_W=128
//      typedef enum logic [1:0] {FILL_EMPTY, FILL_PARTIAL, FILL_FULL} fill_state_e
//  - Sub-module demux_onehot #(NCH): combinational. Inputs en, sel[SELW].
//    Output onehot[NCH], all-zero when en=0 or sel>=NCH. It drives the write enables and out_wr.
//  - Top: channel registers in a generate loop, wr_ptr counter, FSM, sel_err flop.
// TESTING
//  1. rst=1 then release, idle -> all outputs 0, in_ready=1, FSM EMPTY.
//  2. auto_mode=1, 11 back-to-back words 0x..00..0x..0A
//     -> chan k=word k, out_wr walks one-hot 1<<k, all_loaded=1 after the 11th,
//     in_ready=0, 12th word stalls.
//  3. Explicit mode, in_sel=3 data=A, then in_sel=3 data=B
//     -> out_data[3]=B, out_valid=0x008, wr_ptr=0, FSM PARTIAL.
//  4. Explicit mode, in_sel=12 -> sel_err pulses one cycle, out_valid unchanged, out_wr=0.
//  5. clear and in_valid high on the same cycle while in PARTIAL
//     -> in_ready=0, out_valid=0, wr_ptr=0, FSM EMPTY, word not written.
//  6. rst asserted mid-cycle after 5 auto loads
//     -> outputs zero before the next edge; reload of 11 reaches FULL normally.

Source files
------------

// File: rtl/aes_cu_pkg.sv
// Shared definitions for the AES control unit: round-key count, word width
// and the fill-state encoding used by the round-key holding registers.
package aes_cu_pkg;

  localparam int AES_NUM_RK = 11;
  localparam int AES_WORD_W = 128;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_state_e;

endpackage

// File: rtl/demux_onehot.sv
// Combinational select decoder.
// Ports:
//   en      enable; all outputs are zero when low
//   sel     channel index
//   onehot  one bit set at position sel; all-zero when sel >= NCH
module demux_onehot #(
  parameter  int NCH  = 11,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NCH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(sel) < NCH)) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rk_demux_reg.sv
// Registered 1-to-NCH demultiplexer for round-key words, with a valid/ready
// input handshake, explicit or auto-incrementing channel select, per-channel
// loaded flags and a fill-state FSM.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   clear        synchronous flush of channels, flags, pointer and FSM
//   auto_mode    1: write to wr_ptr, 0: write to in_sel
//   in_valid/in_ready/in_sel/in_data   input handshake and word
//   out_data     channel k at [k*WIDTH +: WIDTH]
//   out_valid    per-channel loaded flag
//   out_wr       one-hot strobe of the channel written on the previous edge
//   wr_ptr       next auto-mode target
//   all_loaded   every channel loaded
//   sel_err      one-cycle pulse when an explicit select >= NCH was dropped
//
// state        | meaning
// FILL_EMPTY   | no channel loaded
// FILL_PARTIAL | 1..NCH-1 channels loaded
// FILL_FULL    | all channels loaded; left only via clear or rst
module rk_demux_reg
  import aes_cu_pkg::*;
#(
  parameter  int WIDTH = AES_WORD_W,
  parameter  int NCH   = AES_NUM_RK,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 auto_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH-1:0]       out_wr,
  output logic [SELW-1:0]      wr_ptr,
  output logic                 all_loaded,
  output logic                 sel_err
);

  logic            accept;
  logic [SELW-1:0] tgt;
  logic [NCH-1:0]  wen;
  logic [NCH-1:0]  valid_nxt;
  logic            sel_err_nxt;
  int unsigned     fill_cnt;
  fill_state_e     state;

  assign in_ready    = ~clear & ~(auto_mode & all_loaded);
  assign accept      = in_valid & in_ready;
  assign tgt         = auto_mode ? wr_ptr : in_sel;
  // A dropped out-of-range word is still consumed; it only raises sel_err.
  assign sel_err_nxt = accept & ~auto_mode & (int'(in_sel) >= NCH);

  demux_onehot #(.NCH(NCH)) u_dec (
    .en     (accept),
    .sel    (tgt),
    .onehot (wen)
  );

  assign valid_nxt = out_valid | wen;
  assign fill_cnt  = $countones(valid_nxt);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data[k*WIDTH +: WIDTH] <= '0;
      end else if (clear) begin
        out_data[k*WIDTH +: WIDTH] <= '0;
      end else if (wen[k]) begin
        out_data[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_wr    <= '0;
      wr_ptr    <= '0;
      sel_err   <= 1'b0;
    end else begin
      out_wr  <= wen;
      sel_err <= sel_err_nxt;
      if (clear) begin
        out_valid <= '0;
        wr_ptr    <= '0;
      end else begin
        out_valid <= valid_nxt;
        if (accept && auto_mode) begin
          wr_ptr <= (wr_ptr == SELW'(NCH - 1)) ? '0 : wr_ptr + SELW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL_EMPTY;
      all_loaded <= 1'b0;
    end else if (clear) begin
      state      <= FILL_EMPTY;
      all_loaded <= 1'b0;
    end else begin
      case (state)
        FILL_EMPTY, FILL_PARTIAL: begin
          if (fill_cnt == NCH) begin
            state      <= FILL_FULL;
            all_loaded <= 1'b1;
          end else if (fill_cnt != 0) begin
            state      <= FILL_PARTIAL;
            all_loaded <= 1'b0;
          end
        end
        FILL_FULL: begin
          all_loaded <= 1'b1;
        end
        default: begin
          state      <= FILL_EMPTY;
          all_loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rk_demux_reg.sv
// Self-checking bench for rk_demux_reg: a reference model predicts each
// cycle's outputs, pushes them to a scoreboard queue, and they are popped
// and compared after the clock edge.
module tb_rk_demux_reg;
  import aes_cu_pkg::*;

  localparam int WIDTH = 128;
  localparam int NCH   = 11;
  localparam int SELW  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic                 auto_mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_wr;
  logic [SELW-1:0]      wr_ptr;
  logic                 all_loaded;
  logic                 sel_err;

  rk_demux_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .auto_mode  (auto_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_wr     (out_wr),
    .wr_ptr     (wr_ptr),
    .all_loaded (all_loaded),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   wr;
    logic [NCH-1:0]   valid;
    logic [SELW-1:0]  ptr;
    logic             full;
    logic             err;
    int               ch;
    logic [WIDTH-1:0] dat;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_data[NCH];
  logic [NCH-1:0]   m_valid;
  logic [SELW-1:0]  m_ptr;
  logic             m_full;
  int               n_chk  = 0;
  int               n_fail = 0;

  localparam logic [WIDTH-1:0] WA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [WIDTH-1:0] WB = 128'hBBBB_7777_8888_9999_0000_1234_5678_9ABC;
  localparam logic [WIDTH-1:0] WC = 128'hCCCC_DEAD_BEEF_0000_0000_0000_0000_0001;
  localparam logic [WIDTH-1:0] WD = 128'hDDDD_0123_4567_89AB_CDEF_FEDC_BA98_7654;

  function automatic logic [WIDTH-1:0] word(input int k);
    return {120'hA5A5_5A5A_0F0F_F0F0_C3C3_3C3C_9696_69, 8'(k)};
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_data[i] = '0;
    m_valid = '0;
    m_ptr   = '0;
    m_full  = 1'b0;
    sb.delete();
  endtask

  task automatic check_chans(input string tag);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s_chan%0d", tag, i), out_data[i*WIDTH +: WIDTH], m_data[i]);
  endtask

  task automatic cycle(input logic v, input logic clr, input logic am,
                       input logic [SELW-1:0] sel, input logic [WIDTH-1:0] d);
    exp_t e;
    exp_t g;
    logic rdy;
    int   tgt;
    @(negedge clk);
    in_valid  = v;
    clear     = clr;
    auto_mode = am;
    in_sel    = sel;
    in_data   = d;
    #1;
    rdy = !clr && !(am && m_full);
    chk("in_ready", {127'b0, in_ready}, {127'b0, rdy});
    e.wr  = '0;
    e.err = 1'b0;
    e.ch  = -1;
    e.dat = '0;
    if (clr) begin
      for (int i = 0; i < NCH; i++) m_data[i] = '0;
      m_valid = '0;
      m_ptr   = '0;
    end else if (v && rdy) begin
      tgt = am ? int'(m_ptr) : int'(sel);
      if (tgt >= NCH) begin
        e.err = 1'b1;
      end else begin
        m_data[tgt]  = d;
        m_valid[tgt] = 1'b1;
        e.wr[tgt]    = 1'b1;
        e.ch         = tgt;
        e.dat        = d;
        if (am) m_ptr = (int'(m_ptr) == NCH - 1) ? 4'd0 : m_ptr + 4'd1;
      end
    end
    m_full  = &m_valid;
    e.valid = m_valid;
    e.ptr   = m_ptr;
    e.full  = m_full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 128'd1, 128'd0);
    end else begin
      g = sb.pop_front();
      chk("out_wr",     {117'b0, out_wr},     {117'b0, g.wr});
      chk("out_valid",  {117'b0, out_valid},  {117'b0, g.valid});
      chk("wr_ptr",     {124'b0, wr_ptr},     {124'b0, g.ptr});
      chk("all_loaded", {127'b0, all_loaded}, {127'b0, g.full});
      chk("sel_err",    {127'b0, sel_err},    {127'b0, g.err});
      if (g.ch >= 0) chk($sformatf("data_ch%0d", g.ch), out_data[g.ch*WIDTH +: WIDTH], g.dat);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {117'b0, out_valid}, 128'd0);
    chk({tag, "_wr"},    {117'b0, out_wr},    128'd0);
    chk({tag, "_ptr"},   {124'b0, wr_ptr},    128'd0);
    chk({tag, "_full"},  {127'b0, all_loaded}, 128'd0);
    chk({tag, "_err"},   {127'b0, sel_err},   128'd0);
    chk({tag, "_data"},  {127'b0, |out_data}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    auto_mode = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    #1;
    check_zero("reset");
    chk("reset_ready", {127'b0, in_ready}, 128'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, '0);

    // 2: auto fill of all 11 channels, then stall
    for (int k = 0; k < NCH; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 4'd0, word(k));
      chk($sformatf("walk_wr%0d", k), {117'b0, out_wr}, 128'd1 << k);
    end
    chk("fill_valid", {117'b0, out_valid}, 128'h7ff);
    chk("fill_full",  {127'b0, all_loaded}, 128'd1);
    check_chans("fill");
    cycle(1'b1, 1'b0, 1'b1, 4'd0, word(11));
    chk("stall_wr",    {117'b0, out_wr}, 128'd0);
    chk("stall_chan0", out_data[0 +: WIDTH], word(0));
    cycle(1'b0, 1'b1, 1'b0, 4'd0, '0);
    check_zero("clear1");

    // 3: explicit overwrite of channel 3
    cycle(1'b1, 1'b0, 1'b0, 4'd3, WA);
    cycle(1'b1, 1'b0, 1'b0, 4'd3, WB);
    chk("ovw_valid", {117'b0, out_valid}, 128'h008);
    chk("ovw_ptr",   {124'b0, wr_ptr},    128'd0);
    chk("ovw_full",  {127'b0, all_loaded}, 128'd0);
    chk("ovw_chan3", out_data[3*WIDTH +: WIDTH], WB);

    // 4: out-of-range explicit select
    cycle(1'b1, 1'b0, 1'b0, 4'd12, WC);
    chk("selerr_pulse", {127'b0, sel_err}, 128'd1);
    chk("selerr_valid", {117'b0, out_valid}, 128'h008);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("selerr_gone", {127'b0, sel_err}, 128'd0);
    check_chans("selerr");

    // mode switching mid-load keeps pointer and contents
    cycle(1'b1, 1'b0, 1'b1, 4'd0, word(20));
    cycle(1'b1, 1'b0, 1'b1, 4'd0, word(21));
    cycle(1'b1, 1'b0, 1'b0, 4'd7, WD);
    cycle(1'b1, 1'b0, 1'b1, 4'd0, word(22));
    chk("mix_ptr", {124'b0, wr_ptr}, 128'd3);
    check_chans("mix");

    // 5: clear wins over in_valid
    cycle(1'b1, 1'b1, 1'b0, 4'd5, WD);
    check_zero("clear2");
    cycle(1'b0, 1'b0, 1'b0, 4'd0, '0);

    // 6: async reset mid-load, then full reload
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 4'd0, word(30 + k));
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) cycle(1'b1, 1'b0, 1'b1, 4'd0, word(40 + k));
    chk("reload_full",  {127'b0, all_loaded}, 128'd1);
    chk("reload_valid", {117'b0, out_valid}, 128'h7ff);
    check_chans("reload");
    cycle(1'b0, 1'b0, 1'b0, 4'd0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
